// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: FSM state encoding, parity-type constants
// and the parity check helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // True when the data XOR plus the received parity bit violates the parity type.
  function automatic logic par_mismatch(input logic data_xor, input logic par_bit,
                                        input logic par_type);
    logic total;
    total = data_xor ^ par_bit;
    return (par_type == PAR_ODD) ? (total != 1'b1) : (total != PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop rx synchronizer plus the bclk tick counter that produces the
// half-bit (START) or full-bit sampling strobe.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLING = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bclk,
  input  logic i_rx,
  input  logic i_clr,
  input  logic i_half,
  output logic o_rx_s,
  output logic o_mid_tick
);

  localparam int CNT_W = $clog2(OVERSAMPLING);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLING - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_target;

  assign w_target   = i_half ? HALF_M1 : FULL_M1;
  assign o_mid_tick = i_bclk & (r_cnt == w_target);
  assign o_rx_s     = r_sync[1];

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
      r_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_sync <= {r_sync[0], i_rx};
      if (i_bclk) begin
        if (i_clr || o_mid_tick) begin
          r_cnt <= {CNT_W{1'b0}};
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_top.sv
// Oversampled UART receiver: start/data/parity/stop framing with parity and
// framing error flags qualified by a one-clk dataValid pulse.
module uart_rx_top
  import uart_rx_pkg::*;
#(
  parameter int DATAWIDTH    = 8,
  parameter int OVERSAMPLING = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bclk,
  input  logic                 rx_in,
  input  logic                 parEnable,
  input  logic                 parityType,
  output logic [DATAWIDTH-1:0] dataOut,
  output logic                 dataValid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int BW = $clog2(DATAWIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATAWIDTH - 1);

  rx_state_e            r_state;
  logic [DATAWIDTH-1:0] r_shift;
  logic [BW-1:0]        r_bitcnt;
  logic                 r_xor;
  logic                 r_par_en;
  logic                 r_par_type;
  logic                 r_par_err;
  logic                 w_rx_s;
  logic                 w_mid;
  logic                 w_clr;
  logic                 w_half;

  assign w_clr  = (r_state == IDLE) || (r_state == BREAK);
  assign w_half = (r_state == START);

  uart_rx_sampler #(
    .OVERSAMPLING(OVERSAMPLING)
  ) u_sampler (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_bclk    (bclk),
    .i_rx      (rx_in),
    .i_clr     (w_clr),
    .i_half    (w_half),
    .o_rx_s    (w_rx_s),
    .o_mid_tick(w_mid)
  );

  // Receive FSM with registered outputs; error flags only live alongside dataValid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_shift       <= {DATAWIDTH{1'b0}};
      r_bitcnt      <= {BW{1'b0}};
      r_xor         <= 1'b0;
      r_par_en      <= 1'b0;
      r_par_type    <= 1'b0;
      r_par_err     <= 1'b0;
      dataOut       <= {DATAWIDTH{1'b0}};
      dataValid     <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      dataValid     <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bclk && !w_rx_s) begin
            r_state    <= START;
            busy       <= 1'b1;
            r_par_en   <= parEnable;
            r_par_type <= parityType;
          end
        end
        START: begin
          if (w_mid) begin
            if (w_rx_s) begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end else begin
              r_state   <= DATA;
              r_bitcnt  <= {BW{1'b0}};
              r_xor     <= 1'b0;
              r_par_err <= 1'b0;
            end
          end
        end
        DATA: begin
          if (w_mid) begin
            r_shift  <= {w_rx_s, r_shift[DATAWIDTH-1:1]};
            r_xor    <= r_xor ^ w_rx_s;
            r_bitcnt <= r_bitcnt + BW'(1);
            if (r_bitcnt == LAST_BIT) begin
              r_state <= r_par_en ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (w_mid) begin
            r_par_err <= par_mismatch(r_xor, w_rx_s, r_par_type);
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_mid) begin
            dataOut       <= r_shift;
            dataValid     <= 1'b1;
            parity_error  <= r_par_en & r_par_err;
            framing_error <= ~w_rx_s;
            if (w_rx_s) begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end else begin
              r_state <= BREAK;
            end
          end
        end
        // A held-low line must return high before another start bit is accepted.
        BREAK: begin
          if (w_rx_s) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed self-checking bench for uart_rx_top: clean, parity, false-start,
// framing/break, back-to-back, slow-bclk and mid-frame reset scenarios.
module tb_uart_rx_top;

  localparam int DW = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bclk = 1'b0;
  logic          rx_in = 1'b1;
  logic          parEnable = 1'b0;
  logic          parityType = 1'b0;
  logic [DW-1:0] dataOut;
  logic          dataValid;
  logic          parity_error;
  logic          framing_error;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;
  int bdiv     = 1;
  int bcnt     = 0;

  // Each entry: {busy, framing_error, parity_error, dataOut} captured on a dataValid cycle.
  logic [10:0] rec_q[$];

  uart_rx_top #(
    .DATAWIDTH   (DW),
    .OVERSAMPLING(OS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bclk         (bclk),
    .rx_in        (rx_in),
    .parEnable    (parEnable),
    .parityType   (parityType),
    .dataOut      (dataOut),
    .dataValid    (dataValid),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bcnt >= bdiv - 1) begin
      bcnt <= 0;
      bclk <= 1'b1;
    end else begin
      bcnt <= bcnt + 1;
      bclk <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (dataValid) rec_q.push_back({busy, framing_error, parity_error, dataOut});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (bclk) k++;
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic pop_frame(input string tag, input logic [7:0] d, input logic pe,
                           input logic fe, input logic bsy);
    logic [10:0] e;
    chk({tag, "_present"}, 32'(rec_q.size() != 0), 32'd1);
    if (rec_q.size() != 0) begin
      e = rec_q.pop_front();
      chk({tag, "_data"}, 32'(e[7:0]), 32'(d));
      chk({tag, "_perr"}, 32'(e[8]), 32'(pe));
      chk({tag, "_ferr"}, 32'(e[9]), 32'(fe));
      chk({tag, "_busy"}, 32'(e[10]), 32'(bsy));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_dataOut"}, 32'(dataOut), 32'h0);
    chk({tag, "_dataValid"}, 32'(dataValid), 32'h0);
    chk({tag, "_perr"}, 32'(parity_error), 32'h0);
    chk({tag, "_ferr"}, 32'(framing_error), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b1;
    wait_ticks(4);

    // Plain frame, no parity.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    chk("a5_count", 32'(rec_q.size()), 32'd1);
    pop_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_busy_after", 32'(busy), 32'd0);

    // Even parity: correct, then wrong parity bit.
    parEnable  = 1'b1;
    parityType = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    wait_ticks(4);
    chk("even_ok_count", 32'(rec_q.size()), 32'd1);
    pop_frame("even_ok", 8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    wait_ticks(4);
    chk("even_bad_count", 32'(rec_q.size()), 32'd1);
    pop_frame("even_bad", 8'h3C, 1'b1, 1'b0, 1'b0);

    // Odd parity with four ones needs parity bit 1.
    parityType = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    wait_ticks(4);
    pop_frame("odd_ok", 8'h3C, 1'b0, 1'b0, 1'b0);
    parEnable  = 1'b0;
    parityType = 1'b0;

    // False start: 4 low ticks, checked at the half-bit point.
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    wait_ticks(6);
    chk("false_start_busy_before", 32'(busy), 32'd1);
    wait_ticks(1);
    chk("false_start_busy_after", 32'(busy), 32'd0);
    wait_ticks(20);
    chk("false_start_no_valid", 32'(rec_q.size()), 32'd0);

    // Framing error followed by a held-low line.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    wait_ticks(40);
    chk("break_count", 32'(rec_q.size()), 32'd1);
    pop_frame("ferr", 8'h55, 1'b0, 1'b1, 1'b1);
    chk("break_busy_held", 32'(busy), 32'd1);
    rx_in = 1'b1;
    wait_ticks(4);
    chk("break_busy_released", 32'(busy), 32'd0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    chk("after_break_count", 32'(rec_q.size()), 32'd1);
    pop_frame("after_break", 8'h0F, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames, bclk every clk then every 3rd clk.
    for (int pass = 0; pass < 2; pass++) begin
      bdiv = (pass == 0) ? 1 : 3;
      wait_ticks(4);
      send_frame(8'h81, 1'b0, 1'b0, 1'b1);
      send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
      wait_ticks(4);
      chk($sformatf("b2b%0d_count", pass), 32'(rec_q.size()), 32'd2);
      pop_frame($sformatf("b2b%0d_first", pass), 8'h81, 1'b0, 1'b0, 1'b0);
      pop_frame($sformatf("b2b%0d_second", pass), 8'h7E, 1'b0, 1'b0, 1'b0);
    end
    bdiv = 1;
    wait_ticks(4);

    // Reset in the middle of data bit 4 of 0xFF.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_in = 1'b1;
    wait_ticks(8);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs_zero("midreset");
    rst = 1'b1;
    wait_ticks(8 + 4 * OS);
    chk("midreset_no_valid", 32'(rec_q.size()), 32'd0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    chk("post_reset_count", 32'(rec_q.size()), 32'd1);
    pop_frame("post_reset", 8'h12, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
UART receiver: the receive-side counterpart of the team's oversampled UART transmitter.
- Deserializes the rx line into DATAWIDTH-bit words: one start bit, DATAWIDTH data bits LSB-first, optional parity, one stop bit.
- Uses the same bclk oversampling tick as the transmitter.
- Flags parity and framing errors with each frame.
- Sits between the pad-side rx line and the parallel consumer.

Parameters:
- DATAWIDTH, 8, number of data bits per frame.
- OVERSAMPLING, 16, bclk ticks per bit period. Must be even and at least 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- bclk  input  1  one-clk-wide tick at OVERSAMPLING x baud rate.
- rx_in  input  1  serial line, asynchronous to clk, idle high.
- parEnable  input  1  1 means a parity bit is present after the data bits.
- parityType  input  1  0 = even parity, 1 = odd parity.
- dataOut  output  DATAWIDTH  last received word.
- dataValid  output  1  one-clk pulse when a frame completes.
- parity_error  output  1  qualifies dataValid; parity mismatch.
- framing_error  output  1  qualifies dataValid; stop bit sampled low.
- busy  output  1  high while a frame is being received.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - dataOut = 0; dataValid, parity_error, framing_error and busy = 0.
  - Synchronizer flops = 1; tick counter and bit counter = 0.
- rx_in passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s.
- tick counter cnt and bit counter bitcnt change only on cycles where bclk=1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - On bclk with rx_s=0: go to START, cnt=0.
  - Latch parEnable and parityType into internal registers.
  - Input changes mid-frame are ignored.
- START:
  - On bclk: cnt++.
  - When cnt reaches OVERSAMPLING/2-1, check rx_s:
    - rx_s=1: false start, return to IDLE; no outputs pulse.
    - rx_s=0: cnt=0, bitcnt=0, go to DATA.
  - All later samples therefore fall at bit centres.
- DATA:
  - On bclk: cnt++.
  - At cnt=OVERSAMPLING-1: shift rx_s into the shift register MSB, then shift right (LSB-first reception). Update the running XOR, set cnt=0, bitcnt++.
  - After bitcnt reaches DATAWIDTH: go to PARITY if the latched parEnable=1, else STOP.
- PARITY:
  - Sample at cnt=OVERSAMPLING-1.
  - Error when (XOR of data ^ parity bit) != latched parityType, i.e. even parity requires the total XOR to be 0.
  - Go to STOP.
- STOP: sample at cnt=OVERSAMPLING-1, then:
  - Load dataOut with the shift register. dataOut is loaded even on error.
  - Pulse dataValid for exactly one clk in the cycle after the sampling bclk.
  - parity_error and framing_error are valid only in that same cycle and are 0 otherwise. parity_error is always 0 when parity is disabled.
  - Stop sample 1: go to IDLE, so a start bit immediately following is detected (back-to-back frames).
  - Stop sample 0: assert framing_error and go to BREAK.
- BREAK: wait for rx_s=1 on any clk, then go to IDLE. This prevents a held-low line from re-triggering frames.
- busy = 1 in START, DATA, PARITY, STOP and BREAK; 0 in IDLE. busy drops in the same cycle dataValid rises, except after a framing error.
- dataOut holds its value between frames.
- Reset asserted mid-frame: the frame is abandoned and no dataValid is produced. After reset is released, reception resumes from IDLE.

Decomposition:
- Shared include uart_defs: state encodings (3-bit localparams IDLE..BREAK, shared with the transmitter's FSM encoding) and parity-type constants EVEN=0, ODD=1.
- One natural sub-module, uart_rx_sampler: 2-flop synchronizer plus tick counter. It outputs rx_s and a mid_tick strobe (half-bit in START, full-bit elsewhere).
- The FSM, shift register and parity live in the top.

Test Plan (OVERSAMPLING=16, bclk every clk unless noted):
- Frame 0xA5, parEnable=0, correct stop -> dataOut=0xA5, a single dataValid pulse, both error flags 0, busy low after the pulse.
- Frame 0x3C, parEnable=1, parityType=0, parity bit 0 -> dataOut=0x3C, parity_error=0. Repeat with parity bit 1 -> parity_error=1 with dataValid, dataOut=0x3C.
- False start: rx_in low for 4 bclk ticks then high -> back to IDLE, no dataValid, busy low within 1 clk of the check.
- Frame 0x55 with stop bit 0, line then held low for 40 ticks -> dataValid with framing_error=1. No further dataValid while low; next good frame 0x0F is received correctly.
- Two back-to-back frames 0x81 and 0x7E with no idle gap -> two dataValid pulses carrying the correct words. Repeat with bclk every 3rd clk: same results.
- rst=0 during DATA bit 4 of 0xFF, then released -> all outputs 0, no dataValid. The next frame 0x12 is received as 0x12.
